// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR coefficient controller.
package fir_pkg;

    localparam int NUM_TAPS    = 32;
    localparam int COEF_W      = 12;
    localparam int ADDR_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TAP_W       = $clog2(NUM_TAPS);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RUN
    } coef_state_t;

    typedef logic [COEF_W-1:0] coef_t;

endpackage

// File: rtl/pulse_sync.sv
// Flop-chain synchroniser for an asynchronous level, followed by
// a rising-edge detector giving a one-cycle pulse in the Clk domain.
module pulse_sync #(
    parameter int STAGES = 2
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/fir_coef_ctrl.sv
// FIR coefficient bank: SPI write/read-back, and one-tap-per-cycle
// sequencing to the MAC datapath with writes held off during a pass.
module fir_coef_ctrl
    import fir_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              spi_load,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [COEF_W-1:0] spi_wdata,
    input  logic [ADDR_W-1:0] spi_raddr,
    output logic [COEF_W-1:0] spi_rdata,
    input  logic              sample_valid,
    output logic              tap_valid,
    output logic [TAP_W-1:0]  tap_index,
    output logic [COEF_W-1:0] coef,
    output logic              tap_last,
    output logic              busy,
    input  logic              err_clr,
    output logic              addr_err,
    output logic              wr_overflow,
    output logic              smp_overrun
);

    localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(NUM_TAPS);
    localparam logic [TAP_W-1:0]  TAP_MAX  = TAP_W'(NUM_TAPS - 1);

    coef_state_t      state_q;
    coef_state_t      state_d;
    coef_t            bank_q [NUM_TAPS];
    logic             wr_pend_q;
    logic [TAP_W-1:0] pend_addr_q;
    coef_t            pend_data_q;
    logic             smp_pend_q;
    logic [TAP_W-1:0] tap_cnt_q;

    logic spi_rise;
    logic wr_edge;
    logic bad_edge;
    logic ovf_evt;
    logic in_run;
    logic last_tap;
    logic enter_run;

    pulse_sync #(
        .STAGES (SYNC_STAGES)
    ) u_load_sync (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .d       (spi_load),
        .rise    (spi_rise)
    );

    assign wr_edge   = spi_rise & (spi_addr < ADDR_LIM);
    assign bad_edge  = spi_rise & ~(spi_addr < ADDR_LIM);
    // A write being committed this cycle is not lost, so not an overflow.
    assign ovf_evt   = wr_edge & wr_pend_q & (state_q != WRITE);
    assign in_run    = (state_q == RUN);
    assign last_tap  = (tap_cnt_q == TAP_MAX);
    assign enter_run = (state_q == IDLE) & (state_d == RUN);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (wr_pend_q) begin
                    state_d = WRITE;
                end else if (smp_pend_q || sample_valid) begin
                    state_d = RUN;
                end
            end
            WRITE:   state_d = IDLE;
            RUN:     if (last_tap) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            wr_pend_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            smp_pend_q  <= 1'b0;
            tap_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (wr_edge) begin
                pend_addr_q <= spi_addr[TAP_W-1:0];
                pend_data_q <= spi_wdata;
                wr_pend_q   <= 1'b1;
            end else if (state_q == WRITE) begin
                wr_pend_q <= 1'b0;
            end
            smp_pend_q <= enter_run ? 1'b0 : (smp_pend_q | sample_valid);
            if (enter_run) begin
                tap_cnt_q <= '0;
            end else if (in_run) begin
                tap_cnt_q <= tap_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (state_q == WRITE) begin
            bank_q[pend_addr_q] <= pend_data_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            spi_rdata <= '0;
            tap_valid <= 1'b0;
            tap_index <= '0;
            coef      <= '0;
            tap_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            spi_rdata <= (spi_raddr < ADDR_LIM)
                       ? bank_q[spi_raddr[TAP_W-1:0]] : '0;
            tap_valid <= in_run;
            tap_index <= in_run ? tap_cnt_q : '0;
            coef      <= in_run ? bank_q[tap_cnt_q] : '0;
            tap_last  <= in_run & last_tap;
            busy      <= (state_q != IDLE);
        end
    end

    // New errors take precedence over a clear in the same cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_err    <= 1'b0;
            wr_overflow <= 1'b0;
            smp_overrun <= 1'b0;
        end else begin
            addr_err    <= bad_edge | (addr_err & ~err_clr);
            wr_overflow <= ovf_evt | (wr_overflow & ~err_clr);
            smp_overrun <= (sample_valid & smp_pend_q)
                         | (smp_overrun & ~err_clr);
        end
    end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Self-checking bench for fir_coef_ctrl: tap stream scoreboard plus
// per-scenario checks of read-back, flags, hold-off and reset.
module tb_fir_coef_ctrl;
    import fir_pkg::*;

    typedef struct packed {
        logic [TAP_W-1:0] idx;
        coef_t            cf;
        logic             last;
    } tap_exp_t;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              spi_load = 1'b0;
    logic [ADDR_W-1:0] spi_addr = '0;
    logic [COEF_W-1:0] spi_wdata = '0;
    logic [ADDR_W-1:0] spi_raddr = '0;
    logic [COEF_W-1:0] spi_rdata;
    logic              sample_valid = 1'b0;
    logic              tap_valid;
    logic [TAP_W-1:0]  tap_index;
    logic [COEF_W-1:0] coef;
    logic              tap_last;
    logic              busy;
    logic              err_clr = 1'b0;
    logic              addr_err;
    logic              wr_overflow;
    logic              smp_overrun;

    int       vectors = 0;
    int       miscompares = 0;
    tap_exp_t exp_q[$];
    coef_t    model_bank [NUM_TAPS];

    fir_coef_ctrl dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .spi_load     (spi_load),
        .spi_addr     (spi_addr),
        .spi_wdata    (spi_wdata),
        .spi_raddr    (spi_raddr),
        .spi_rdata    (spi_rdata),
        .sample_valid (sample_valid),
        .tap_valid    (tap_valid),
        .tap_index    (tap_index),
        .coef         (coef),
        .tap_last     (tap_last),
        .busy         (busy),
        .err_clr      (err_clr),
        .addr_err     (addr_err),
        .wr_overflow  (wr_overflow),
        .smp_overrun  (smp_overrun)
    );

    always #5 Clk = ~Clk;

    // Scoreboard: every tap the DUT emits must match the queue head.
    always @(negedge Clk) begin
        tap_exp_t got;
        tap_exp_t want;
        if (Reset_n && tap_valid) begin
            got.idx  = tap_index;
            got.cf   = coef;
            got.last = tap_last;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL tap_unexpected: got idx=%0d coef=%h last=%b, required no tap",
                         tap_index, coef, tap_last);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL tap_stream: got idx=%0d coef=%h last=%b, required idx=%0d coef=%h last=%b",
                             got.idx, got.cf, got.last, want.idx, want.cf, want.last);
                end
            end
        end
    end

    task automatic push_pass();
        tap_exp_t e;
        for (int i = 0; i < NUM_TAPS; i++) begin
            e.idx  = TAP_W'(i);
            e.cf   = model_bank[i];
            e.last = (i == NUM_TAPS - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_sample(input bit expect_pass);
        @(negedge Clk);
        sample_valid = 1'b1;
        if (expect_pass) push_pass();
        @(negedge Clk);
        sample_valid = 1'b0;
    endtask

    task automatic spi_write(input logic [ADDR_W-1:0] a, input coef_t d);
        @(negedge Clk);
        spi_addr  = a;
        spi_wdata = d;
        spi_load  = 1'b1;
        repeat (2) @(negedge Clk);
        spi_load = 1'b0;
        repeat (6) @(negedge Clk);
        if (a < ADDR_W'(NUM_TAPS)) model_bank[a[TAP_W-1:0]] = d;
    endtask

    task automatic read_bank(input logic [ADDR_W-1:0] a, output coef_t v);
        spi_raddr = a;
        repeat (3) @(negedge Clk);
        v = spi_rdata;
    endtask

    task automatic pulse_clr();
        @(negedge Clk);
        err_clr = 1'b1;
        @(negedge Clk);
        err_clr = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || tap_valid || exp_q.size() != 0) && n < budget) begin
            @(negedge Clk);
            n++;
        end
        vectors++;
        if (busy || tap_valid || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL idle_timeout: got busy=%b pending=%0d, required idle within %0d",
                     busy, exp_q.size(), budget);
        end
    endtask

    task automatic test_reset();
        logic [53:0] outs;
        repeat (3) @(negedge Clk);
        outs = {spi_rdata, tap_valid, tap_index, coef, tap_last, busy,
                addr_err, wr_overflow, smp_overrun};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_write_read();
        coef_t v;
        spi_write(8'd5, 12'hA5C);
        read_bank(8'd5, v);
        vectors++;
        if (v !== 12'hA5C) begin
            miscompares++;
            $display("FAIL write_read: got %h, required a5c", v);
        end
        vectors++;
        if (addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL write_addr_err: got %b, required 0", addr_err);
        end
        read_bank(8'd32, v);
        vectors++;
        if (v !== 12'h000) begin
            miscompares++;
            $display("FAIL read_oob: got %h, required 000", v);
        end
    endtask

    task automatic test_tap_pass();
        coef_t v;
        int n;
        for (int i = 0; i < NUM_TAPS; i++) spi_write(ADDR_W'(i), coef_t'(i + 1));
        read_bank(8'd31, v);
        vectors++;
        if (v !== 12'd32) begin
            miscompares++;
            $display("FAIL read_top: got %h, required 020", v);
        end
        pulse_sample(1'b1);
        vectors++;
        if (tap_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: got tap_valid=%b, required 0", tap_valid);
        end
        @(negedge Clk);
        vectors++;
        if (tap_valid !== 1'b1 || tap_index !== '0) begin
            miscompares++;
            $display("FAIL latency_first: got valid=%b idx=%0d, required valid=1 idx=0",
                     tap_valid, tap_index);
        end
        n = 0;
        while (!tap_last && n < 40) begin
            @(negedge Clk);
            n++;
        end
        vectors++;
        if (busy !== 1'b1 || tap_last !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_at_last: got busy=%b last=%b, required 1 1", busy, tap_last);
        end
        @(negedge Clk);
        vectors++;
        if (busy !== 1'b0 || tap_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_fall: got busy=%b valid=%b, required 0 0", busy, tap_valid);
        end
        wait_idle(10);
    endtask

    task automatic test_midrun_write();
        coef_t v;
        spi_write(8'd0, 12'd7);
        pulse_sample(1'b1);
        repeat (2) @(negedge Clk);
        spi_write(8'd0, 12'd9);
        vectors++;
        if (busy !== 1'b1 || tap_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL holdoff_pass: got busy=%b valid=%b, required 1 1", busy, tap_valid);
        end
        wait_idle(60);
        read_bank(8'd0, v);
        vectors++;
        if (v !== 12'd9) begin
            miscompares++;
            $display("FAIL deferred_write: got %h, required 009", v);
        end
        pulse_sample(1'b1);
        wait_idle(60);
    endtask

    task automatic test_addr_err();
        coef_t v;
        spi_write(8'd40, 12'hFFF);
        vectors++;
        if (addr_err !== 1'b1) begin
            miscompares++;
            $display("FAIL addr_err_set: got %b, required 1", addr_err);
        end
        read_bank(8'd8, v);
        vectors++;
        if (v !== model_bank[8]) begin
            miscompares++;
            $display("FAIL addr_err_bank: got %h, required %h", v, model_bank[8]);
        end
        pulse_clr();
        vectors++;
        if (addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL addr_err_clr: got %b, required 0", addr_err);
        end
    endtask

    task automatic test_overflow();
        coef_t v;
        coef_t old;
        old = model_bank[1];
        pulse_sample(1'b1);
        spi_write(8'd1, 12'h111);
        spi_write(8'd1, 12'h222);
        vectors++;
        if (wr_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: got %b, required 1", wr_overflow);
        end
        read_bank(8'd1, v);
        vectors++;
        if (v !== old) begin
            miscompares++;
            $display("FAIL overflow_holdoff: got %h, required %h", v, old);
        end
        wait_idle(60);
        read_bank(8'd1, v);
        vectors++;
        if (v !== 12'h222) begin
            miscompares++;
            $display("FAIL overflow_newest: got %h, required 222", v);
        end
        pulse_clr();
        vectors++;
        if (wr_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clr: got %b, required 0", wr_overflow);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        pulse_sample(1'b1);
        repeat (3) @(negedge Clk);
        pulse_sample(1'b1);
        repeat (3) @(negedge Clk);
        pulse_sample(1'b0);
        vectors++;
        if (smp_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: got %b, required 1", smp_overrun);
        end
        n = 0;
        while (!tap_last && n < 60) begin
            @(negedge Clk);
            n++;
        end
        @(negedge Clk);
        vectors++;
        if (tap_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap: got valid=%b, required 0", tap_valid);
        end
        @(negedge Clk);
        vectors++;
        if (tap_valid !== 1'b1 || tap_index !== '0) begin
            miscompares++;
            $display("FAIL b2b_restart: got valid=%b idx=%0d, required 1 0", tap_valid, tap_index);
        end
        wait_idle(60);
        repeat (6) @(negedge Clk);
        vectors++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_single_extra: got busy=%b, required 0", busy);
        end
        pulse_clr();
    endtask

    task automatic test_reset_midpass();
        logic [53:0] outs;
        coef_t v;
        int n;
        spi_raddr = 8'd1;
        pulse_sample(1'b1);
        n = 0;
        while (!(tap_valid && tap_index == TAP_W'(10)) && n < 40) begin
            @(negedge Clk);
            n++;
        end
        Reset_n = 1'b0;
        exp_q.delete();
        #1;
        outs = {spi_rdata, tap_valid, tap_index, coef, tap_last, busy,
                addr_err, wr_overflow, smp_overrun};
        vectors++;
        if (outs !== '0 || n >= 40) begin
            miscompares++;
            $display("FAIL reset_midpass: got %h, required 0", outs);
        end
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < NUM_TAPS; i++) model_bank[i] = '0;
        repeat (5) @(negedge Clk);
        vectors++;
        if (busy !== 1'b0 || tap_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b valid=%b, required 0 0", busy, tap_valid);
        end
        read_bank(8'd1, v);
        vectors++;
        if (v !== model_bank[1]) begin
            miscompares++;
            $display("FAIL reset_bank1: got %h, required 000", v);
        end
        read_bank(8'd31, v);
        vectors++;
        if (v !== model_bank[31]) begin
            miscompares++;
            $display("FAIL reset_bank31: got %h, required 000", v);
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_TAPS; i++) model_bank[i] = '0;
        test_reset();
        test_write_read();
        test_tap_pass();
        test_midrun_write();
        test_addr_err();
        test_overflow();
        test_back_to_back();
        test_reset_midpass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
